// File: rtl/gate_sweep_checker.sv
// ============================================================================
// Module      : gate_sweep_checker
// Description : Exhaustive truth-table sweeper and checker for N-input
//               NAND/AND/NOR/OR/XOR/XNOR standard cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_checker #(
    parameter int N      = 3,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         zn,
    output logic [N-1:0] a,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] fail_vec,
    output logic         fail_valid
);

    localparam logic [3:0]   C_HOLD_INIT = 4'(SETTLE);
    localparam logic [N-1:0] C_A_ONE     = N'(1);
    localparam logic [N-1:0] C_A_MAX     = {N{1'b1}};
    localparam logic [N:0]   C_ERR_ONE   = (N+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [3:0] r_hold;
    logic       r_bad;
    logic       w_legal;
    logic       w_sample;
    logic       w_last;
    logic       w_exp;
    logic       w_mis;

    assign w_legal  = (op <= 3'd5);
    assign w_sample = (r_state == S_WAIT) && !r_bad && (r_hold == 4'd0);
    assign w_last   = (a == C_A_MAX);

    always_comb begin
        w_exp = 1'b0;
        case (r_op)
            3'd0:    w_exp = ~&a;
            3'd1:    w_exp = &a;
            3'd2:    w_exp = ~|a;
            3'd3:    w_exp = |a;
            3'd4:    w_exp = ^a;
            3'd5:    w_exp = ~^a;
            default: w_exp = 1'b0;
        endcase
    end

    // Written so that an X/Z on zn fails the equality and counts as a mismatch.
    always_comb begin
        w_mis = 1'b1;
        if (zn == w_exp) begin
            w_mis = 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_bad || (w_sample && w_last)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An illegal op passes through WAIT for one cycle with r_bad set and
    // never drives the cell, so its done pulse lands one edge after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= 3'd0;
            r_hold     <= 4'd0;
            r_bad      <= 1'b0;
            a          <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                err_count  <= '0;
                fail_vec   <= '0;
                fail_valid <= 1'b0;
                pass       <= 1'b0;
                r_bad      <= !w_legal;
                if (w_legal) begin
                    r_op   <= op;
                    a      <= '0;
                    r_hold <= C_HOLD_INIT;
                    busy   <= 1'b1;
                end
            end else if ((r_state == S_WAIT) && !r_bad) begin
                if (r_hold != 4'd0) begin
                    r_hold <= r_hold - 4'd1;
                end else begin
                    if (w_mis) begin
                        err_count <= err_count + C_ERR_ONE;
                        if (!fail_valid) begin
                            fail_vec   <= a;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        busy <= 1'b0;
                        pass <= (err_count == '0) && !w_mis;
                    end else begin
                        a      <= a + C_A_ONE;
                        r_hold <= C_HOLD_INIT;
                    end
                end
            end else if (r_state == S_DONE) begin
                r_bad <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Scoreboard bench for gate_sweep_checker (N=3/SETTLE=2 and
//               N=1/SETTLE=0 instances) with directed sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic       zn;
    logic [2:0] a;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] fail_vec;
    int         zmode;

    logic       start1;
    logic [2:0] op1;
    logic       zn1;
    logic [0:0] a1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [1:0] err_count1;
    logic [0:0] fail_vec1;

    // Cell models: 0 = ideal NAND3, 1 = output stuck at 1.
    assign zn  = (zmode == 1) ? 1'b1 : ~&a;
    assign zn1 = ~a1[0];

    gate_sweep_checker #(.N(3), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .zn(zn), .a(a),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    gate_sweep_checker #(.N(1), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .zn(zn1), .a(a1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_vec(fail_vec1), .fail_valid(fail_valid1)
    );

    typedef struct {
        string name;
        int    lat;
        int    err;
        int    fv;
        bit    fvalid;
        bit    pass;
        int    t0;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_done(input exp_t e, input int lat, input int err, input int fv,
                              input bit fvalid, input bit ps, input bit bsy);
        chk({e.name, " latency"}, lat, e.lat);
        chk({e.name, " err_count"}, err, e.err);
        chk({e.name, " fail_valid"}, int'(fvalid), int'(e.fvalid));
        if (e.fvalid) chk({e.name, " fail_vec"}, fv, e.fv);
        chk({e.name, " pass"}, int'(ps), int'(e.pass));
        chk({e.name, " busy at done"}, int'(bsy), 0);
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (done === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("dut0 unexpected done", 1, 0);
            end else begin
                e = sb0.pop_front();
                check_done(e, cyc - e.t0 - 1, int'(err_count), int'(fail_vec),
                           fail_valid, pass, busy);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("dut1 unexpected done", 1, 0);
            end else begin
                e = sb1.pop_front();
                check_done(e, cyc - e.t0 - 1, int'(err_count1), int'(fail_vec1),
                           fail_valid1, pass1, busy1);
            end
        end
    end

    // Issues a start on dut0 and returns at the negedge just after the sampling edge.
    task automatic start0(input string nm, input logic [2:0] o, input int zm, input int lat,
                          input int err, input int fv, input bit fvalid, input bit ps);
        exp_t e;
        @(negedge clk);
        op    = o;
        zmode = zm;
        start = 1'b1;
        e = '{nm, lat, err, fv, fvalid, ps, cyc};
        sb0.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait0(input string nm, input bit busy_low);
        bit saw_busy = 1'b0;
        for (int i = 0; i < 100 && sb0.size() != 0; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        if (sb0.size() != 0) begin
            chk({nm, " done timeout"}, 0, 1);
            sb0.delete();
        end
        if (busy_low) chk({nm, " busy seen"}, int'(saw_busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        zmode  = 0;
        start1 = 1'b0;
        op1    = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset a", int'(a), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pass", int'(pass), 0);
        chk("reset err_count", int'(err_count), 0);
        chk("reset fail_valid", int'(fail_valid), 0);
        chk("reset fail_vec", int'(fail_vec), 0);
        rst_n = 1'b1;

        // Ideal NAND3: also walk a through 0..7, three cycles per vector.
        start0("nand_ideal", 3'd0, 0, 24, 0, 0, 1'b0, 1'b1);
        chk("sweep a step 0", int'(a), 0);
        for (int j = 1; j < 24; j++) begin
            @(negedge clk);
            chk($sformatf("sweep a step %0d", j), int'(a), j / 3);
            chk($sformatf("sweep busy step %0d", j), int'(busy), 1);
        end
        wait0("nand_ideal", 1'b0);
        repeat (3) @(negedge clk);
        chk("a held after sweep", int'(a), 7);

        start0("nand_stuck1", 3'd0, 1, 24, 1, 7, 1'b1, 1'b0);
        wait0("nand_stuck1", 1'b0);

        start0("xor_vs_nand", 3'd4, 0, 24, 5, 0, 1'b1, 1'b0);
        wait0("xor_vs_nand", 1'b0);

        start0("illegal_op", 3'd7, 0, 1, 0, 0, 1'b0, 1'b0);
        wait0("illegal_op", 1'b1);
        chk("illegal a unchanged", int'(a), 7);

        // Reset while vector 4 is on the cell.
        start0("aborted", 3'd0, 0, 24, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && a != 3'd4; i++) @(negedge clk);
        chk("reached vector 4", int'(a), 4);
        rst_n = 1'b0;
        sb0.delete();
        #1;
        chk("async reset a", int'(a), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset err_count", int'(err_count), 0);
        chk("async reset pass", int'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        start0("after_reset", 3'd0, 0, 24, 0, 0, 1'b0, 1'b1);
        wait0("after_reset", 1'b0);

        // start re-pulsed and op changed mid-sweep must not disturb it.
        start0("restart_ignored", 3'd0, 0, 24, 0, 0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd5;
        wait0("restart_ignored", 1'b0);

        // N=1, SETTLE=0 inverter-as-NAND1 sweep.
        @(negedge clk);
        op1    = 3'd0;
        start1 = 1'b1;
        sb1.push_back('{"nand1", 2, 0, 0, 1'b0, 1'b1, cyc});
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 20 && sb1.size() != 0; i++) @(negedge clk);
        if (sb1.size() != 0) begin
            chk("nand1 done timeout", 0, 1);
            sb1.delete();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
